// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery ladder datapath.
// Holds the default word geometry, the resolver FSM states and the redundant-word type.
package mont_pkg;
  localparam int DEF_NUM_WORDS = 35;
  localparam int DEF_BIT_LEN   = 17;
  localparam int DEF_WORD_LEN  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cr_state_t;

  typedef logic [DEF_BIT_LEN-1:0] rword_t;
endpackage

// File: rtl/carry_add_word.sv
// One column of carry resolution: adds an incoming carry to a redundant word.
// The word is split into a resolved data word and the carry for the next column.
module carry_add_word #(
  parameter int BIT_LEN  = 17,
  parameter int WORD_LEN = 16
) (
  input  logic [BIT_LEN-1:0]  i_word,
  input  logic [1:0]          i_carry,
  output logic [WORD_LEN-1:0] o_word,
  output logic [1:0]          o_carry
);
  logic [WORD_LEN+1:0] w_sum;

  // Worst case is 0x1FFFF + 2, so the carry out never exceeds 2.
  assign w_sum   = (WORD_LEN+2)'(i_word) + (WORD_LEN+2)'(i_carry);
  assign o_word  = w_sum[WORD_LEN-1:0];
  assign o_carry = w_sum[WORD_LEN+1:WORD_LEN];
endmodule

// File: rtl/carry_resolve_seq.sv
// Sequential carry resolver: captures a redundant product, ripples carries one word
// per cycle and presents the packed binary result through a valid/ready handshake.
module carry_resolve_seq
  import mont_pkg::*;
#(
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int BIT_LEN   = DEF_BIT_LEN,
  parameter int WORD_LEN  = DEF_WORD_LEN
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BIT_LEN-1:0]            in_words [NUM_WORDS],
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_WORDS*WORD_LEN-1:0] out_data,
  output logic [1:0]                    out_carry,
  output cr_state_t                     dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // a producer holds valid (and its data) until that edge, ready never waits on valid.
  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  cr_state_t                     r_state;
  logic [IDX_W-1:0]              r_idx;
  logic [1:0]                    r_carry;
  logic [BIT_LEN-1:0]            r_words [NUM_WORDS];
  logic                          r_in_ready;
  logic                          r_out_valid;
  logic [NUM_WORDS*WORD_LEN-1:0] r_out_data;
  logic [1:0]                    r_out_carry;

  logic [WORD_LEN-1:0]           w_sum_word;
  logic [1:0]                    w_sum_carry;

  carry_add_word #(
    .BIT_LEN (BIT_LEN),
    .WORD_LEN(WORD_LEN)
  ) u_add (
    .i_word (r_words[r_idx]),
    .i_carry(r_carry),
    .o_word (w_sum_word),
    .o_carry(w_sum_carry)
  );

  // The operand store needs no reset: it is always written before it is read.
  always_ff @(posedge clk) begin
    if (in_valid && r_in_ready) begin
      r_words <= in_words;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_carry <= '0;
      r_idx       <= '0;
      r_carry     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_idx      <= '0;
            r_carry    <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_out_data[r_idx*WORD_LEN +: WORD_LEN] <= w_sum_word;
          r_carry <= w_sum_carry;
          r_idx   <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            r_out_carry <= w_sum_carry;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_carry = r_out_carry;
  assign dbg_state = r_state;
endmodule

// File: doc/carry_resolve_seq.md
# carry_resolve_seq

Sequential carry-resolution stage that takes the redundant-form product emitted by `multiplier_256` and produces the plain packed binary result. The multiplier's output is an array of 17-bit words, each word's bit 16 being a carry into the next 16-bit position. This block accepts one such array through a valid/ready handshake and ripples the carries one word per cycle. It then presents the packed result through a second valid/ready handshake, and sits directly downstream of the multiplier in the Montgomery ladder datapath.

## Interface
Parameters:
- `NUM_WORDS`, 35: number of redundant words per operand (2*17+1).
- `BIT_LEN`, 17: width of each input word (16 data bits + 1 carry bit).
- `WORD_LEN`, 16: width of each resolved output word.

Ports:
- `clk`  input  1  single clock; all state on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  `in_words` holds a product to resolve.
- `in_ready`  output  1  block can accept a product.
- `in_words`  input  `[BIT_LEN-1:0] [NUM_WORDS]`  redundant product; value = sum of `in_words[j]`·2^(WORD_LEN·j).
- `out_valid`  output  1  `out_data`/`out_carry` hold a resolved result.
- `out_ready`  input  1  consumer accepts the result.
- `out_data`  output  `NUM_WORDS*WORD_LEN`  packed binary result, word j at bits [16j+15:16j].
- `out_carry`  output  2  carry out of the top word, range 0..2.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`: capture all `in_words` into an internal word register array, set `idx`=0 and `carry`=0, and go to RUN.
- RUN, once per cycle:
  - `sum = words[idx] + carry`, 18 bits wide.
  - `out_data` slice idx ← `sum[15:0]`.
  - `carry` ← `sum[17:16]`.
  - `idx` ← `idx`+1.
  - When `idx == NUM_WORDS-1`: write `out_carry` ← the final carry and go to DONE.
- Width rule: the carry never exceeds 2, because `sum` ≤ 0x1FFFF+2. A 2-bit carry register is sufficient, with no overflow.
- DONE:
  - `out_valid`=1. `out_data` and `out_carry` are held stable.
  - On `out_valid && out_ready`: go to IDLE.
- `in_ready`=0 in RUN and DONE. `in_valid` is ignored there and not captured.
- `out_data` is updated only in RUN. Words not yet written hold their previous contents, but `out_valid` is 0 throughout RUN.
- Reset mid-operation aborts immediately. Any partially resolved result is discarded and never presented.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `out_data`=0, `out_carry`=0, `idx`=0, `carry`=0.
- Latency: with the input accepted at edge N, `out_valid` rises after edge N+NUM_WORDS (35 cycles of RUN).
- Throughput: one result per NUM_WORDS+2 cycles at best, with `out_ready` held at 1 (accept, 35 RUN cycles, DONE handshake, then back to IDLE).
- No bypass:
  - A DONE handshake returns to IDLE on that edge.
  - `in_ready` asserts in the following cycle.
  - The earliest new capture is one cycle later.
- `out_valid` stays high with data stable for any number of cycles of `out_ready`=0.
- `in_words` must be stable only in the capture cycle.

## Structure
- Shared package `mont_pkg`:
  - `NUM_WORDS`, `BIT_LEN` and `WORD_LEN` defaults.
  - The state enum `cr_state_t` (IDLE, RUN, DONE).
  - The redundant-word typedef `rword_t` (`logic [BIT_LEN-1:0]`).
- One natural combinational sub-module, `carry_add_word`: inputs a 17-bit word and a 2-bit carry; outputs a 16-bit word and a 2-bit carry. All other logic stays in the top module.

## Test plan
- All words 0 → after 35 RUN cycles: `out_valid`=1, `out_data`=0, `out_carry`=0.
- `in_words[0]`=0x1FFFF, rest 0 → `out_data`=0x1FFFF (word0=0xFFFF, word1=0x0001), `out_carry`=0.
- All words 0x1FFFF → word0=0xFFFF, word1=0x0000, words2..34=0x0001, `out_carry`=2.
- Golden check: drive random 272-bit A,B through `multiplier_256` into this block for 200 products. Each result must satisfy {`out_carry`,`out_data`} == A*B; the latency between accept and `out_valid` must be 35 cycles.
- Back-pressure: hold `out_ready`=0 for 10 cycles in DONE → `out_valid` stays 1, data unchanged, `in_ready`=0, and a pulsed `in_valid` is not captured. On release, `in_ready`=1 the next cycle.
- Assert `rst` at RUN cycle 12 → `out_valid`=0 and `in_ready`=1 immediately. A following all-zero product resolves to 0 with no residue from the aborted run.
